load_store_unit: RTL and testbench

- Initiator side of the data-memory interface of the RISC-V core.
- Accepts one load/store request at a time from the execute stage and drives the word-addressed data memory's MemRead/MemWrite/Mem_Addr/wr_data; consumes its combinational rd_data.
- Performs alignment and range checks, byte/halfword extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Sits between the ALU/control path and the data memory; multi-cycle, so the core stalls on req_ready/resp_valid.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and response error codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_e;

  localparam logic [1:0] ERR_MISALIGN = 2'd0;
  localparam logic [1:0] ERR_FUNCT3   = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_RSVD     = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and the
// sub-word merge used by the read-modify-write store path.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU: load_data = {24'h0, byte_sel};
      F3_HU: load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    // Only the addressed lane takes new data; the rest keeps the old word.
    merged = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, alignment/range checks, sub-word
// read-modify-write. Optional perf counters under `LSU_PERF_CNT_EN`.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [1:0]    resp_err_code,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] Mem_Addr,
  output logic [31:0]   wr_data,
  input  logic [31:0]   rd_data,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0]   load_cnt,
  output logic [31:0]   store_cnt,
  output logic [31:0]   err_cnt,
`endif
  output lsu_state_e    dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE. resp_valid is a single-cycle pulse with no
  // backpressure, so the core must be ready to take it.

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  lsu_state_e    state;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [1:0]    err_code_q;

  logic          f3_illegal;
  logic          misalign;
  logic          out_of_range;
  logic          req_err;
  logic [1:0]    req_code;
  logic [31:0]   load_data;
  logic [31:0]   merged;

  always_comb begin
    if (req_write) f3_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else           f3_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (req_funct3)
      F3_H, F3_HU: misalign = req_addr[0];
      F3_W:        misalign = (req_addr[1:0] != 2'b00);
      default:     misalign = 1'b0;
    endcase
    // Full word index is compared so high address bits never alias into range.
    out_of_range = ({2'b00, req_addr[AW-1:2]} >= DEPTH_W);
    req_err      = f3_illegal | misalign | out_of_range;
    if (f3_illegal)    req_code = ERR_FUNCT3;
    else if (misalign) req_code = ERR_MISALIGN;
    else               req_code = ERR_RANGE;
  end

  lsu_align u_align (
    .word      (rd_data),
    .addr_lo   (addr_q[1:0]),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q       <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rdata_q    <= 32'h0;
            err_q      <= req_err;
            err_code_q <= req_err ? req_code : 2'd0;
            if (req_err)                 state <= S_RESP;
            else if (!req_write)         state <= S_LOAD;
            else if (req_funct3 == F3_W) state <= S_STORE;
            else                         state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          rdata_q <= load_data;
          state   <= S_RESP;
        end
        S_RMW_RD: begin
          wdata_q <= merged;
          state   <= S_STORE;
        end
        S_STORE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic write_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q   <= 1'b0;
      load_cnt  <= 32'h0;
      store_cnt <= 32'h0;
      err_cnt   <= 32'h0;
    end else begin
      if (state == S_IDLE && req_valid) write_q <= req_write;
      if (state == S_RESP) begin
        if (err_q)        err_cnt   <= err_cnt + 32'd1;
        else if (write_q) store_cnt <= store_cnt + 32'd1;
        else              load_cnt  <= load_cnt + 32'd1;
      end
    end
  end
`endif

  // Reset is folded into req_ready so nothing is offered while reset is held.
  assign req_ready     = (state == S_IDLE) && reset;
  assign MemRead       = (state == S_LOAD) || (state == S_RMW_RD);
  assign MemWrite      = (state == S_STORE);
  assign Mem_Addr      = (MemRead || MemWrite) ? {2'b00, addr_q[AW-1:2]} : '0;
  assign wr_data       = MemWrite ? wdata_q : 32'h0;
  assign resp_valid    = (state == S_RESP);
  assign resp_rdata    = resp_valid ? rdata_q : 32'h0;
  assign resp_err      = resp_valid && err_q;
  assign resp_err_code = resp_valid ? err_code_q : 2'd0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory and a
// scoreboard of expected {err, code, rdata} responses.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [1:0]    resp_err_code;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] Mem_Addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
`ifdef LSU_PERF_CNT_EN
  logic [31:0]   load_cnt;
  logic [31:0]   store_cnt;
  logic [31:0]   err_cnt;
`endif
  lsu_state_e    dbg_state;

  load_store_unit #(.DEPTH(64), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_err_code (resp_err_code),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Mem_Addr      (Mem_Addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
`ifdef LSU_PERF_CNT_EN
    .load_cnt      (load_cnt),
    .store_cnt     (store_cnt),
    .err_cnt       (err_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = i * 32'h9E37_79B1;
      ref_mem[i] = i * 32'h9E37_79B1;
    end
    mem[5]     = 32'h8899_AABB;
    ref_mem[5] = 32'h8899_AABB;
    mem[8]     = 32'h1234_5678;
    ref_mem[8] = 32'h1234_5678;
  end

  always_comb begin
    rd_data = 32'h0;
    if (MemRead && Mem_Addr < 64) rd_data = mem[Mem_Addr[5:0]];
  end

  always @(posedge clk) begin
    if (MemWrite && Mem_Addr < 64) mem[Mem_Addr[5:0]] = wr_data;
  end

  // ---------------- scoreboard state ----------------
  logic [34:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  int          obs_lat;
  int          obs_rd_cyc;
  int          obs_wr_cyc;
  logic [31:0] obs_rd_addr;
  logic [31:0] obs_wr_data;

  function automatic logic [34:0] ok_rsp(input logic [31:0] d);
    return {1'b0, 2'b00, d};
  endfunction

  function automatic logic [34:0] err_rsp(input logic [1:0] c);
    return {1'b1, c, 32'h0};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = w >> (8 * a[1:0]);
    sh = w >> (16 * a[1]);
    case (f3)
      3'd0:    return {{24{sb[7]}}, sb[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return sb & 32'h0000_00FF;
      3'd5:    return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                            input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] m;
    logic [31:0] d;
    case (f3)
      3'd0: begin m = 32'h0000_00FF << (8 * a[1:0]); d = (wd & 32'h0000_00FF) << (8 * a[1:0]); end
      3'd1: begin m = 32'h0000_FFFF << (16 * a[1]);  d = (wd & 32'h0000_FFFF) << (16 * a[1]); end
      default: begin m = 32'hFFFF_FFFF; d = wd; end
    endcase
    return (old & ~m) | (d & m);
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [34:0] exp);
    int          w;
    logic [34:0] got;
    logic [34:0] e;
    exp_q.push_back(exp);
    obs_lat    = -1;
    obs_rd_cyc = -1;
    obs_wr_cyc = -1;
    got        = '0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (MemRead && obs_rd_cyc < 0) begin obs_rd_cyc = k; obs_rd_addr = Mem_Addr; end
      if (MemWrite && obs_wr_cyc < 0) begin obs_wr_cyc = k; obs_wr_data = wr_data; end
      if (resp_valid) begin
        obs_lat = k;
        got = {resp_err, resp_err_code, resp_rdata};
        break;
      end
    end
    e = exp_q.pop_front();
    n_vec++;
    if (obs_lat < 0) begin
      n_err++;
      $display("FAIL resp_timeout: addr=%h no resp_valid within 8 cycles, expected %h", addr, e);
    end else if (got !== e) begin
      n_err++;
      $display("FAIL resp addr=%h f3=%0d wr=%0b: got %h expected %h", addr, f3, wr, got, e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    #3;
    n_vec++;
    if ({req_ready, resp_valid, MemRead, MemWrite} !== 4'b0000 || Mem_Addr !== 32'h0 ||
        resp_rdata !== 32'h0 || wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%b wr=%b addr=%h expected all 0",
               req_ready, resp_valid, MemRead, MemWrite, Mem_Addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b state=%0d expected rdy=1 state=IDLE",
               req_ready, dbg_state);
    end
  endtask

  task automatic test_loads();
    do_req(1'b0, 3'd0, 32'h17, 32'h0, ok_rsp(32'hFFFF_FF88));
    n_vec++;
    if (obs_lat !== 2 || obs_rd_cyc !== 1 || obs_rd_addr !== 32'd5) begin
      n_err++;
      $display("FAIL lb_timing: got lat=%0d rd_cyc=%0d addr=%0d expected 2 1 5",
               obs_lat, obs_rd_cyc, obs_rd_addr);
    end
    do_req(1'b0, 3'd5, 32'h14, 32'h0, ok_rsp(32'h0000_AABB));
    do_req(1'b0, 3'd1, 32'h16, 32'h0, ok_rsp(32'hFFFF_8899));
    do_req(1'b0, 3'd4, 32'h17, 32'h0, ok_rsp(32'h0000_0088));
    do_req(1'b0, 3'd2, 32'h14, 32'h0, ok_rsp(32'h8899_AABB));
    n_vec++;
    if (obs_lat !== 2 || obs_wr_cyc !== -1) begin
      n_err++;
      $display("FAIL lw_timing: got lat=%0d wr_cyc=%0d expected 2 -1", obs_lat, obs_wr_cyc);
    end
  endtask

  task automatic test_random_loads();
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [31:0] a;
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;
    for (int i = 0; i < 10; i++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      a  = {$urandom_range(0, 63), 2'b00};
      if (f3 == 3'd0 || f3 == 3'd4)      a[1:0] = 2'($urandom_range(0, 3));
      else if (f3 == 3'd1 || f3 == 3'd5) a[1]   = 1'($urandom_range(0, 1));
      do_req(1'b0, f3, a, 32'h0, ok_rsp(ref_load(ref_mem[a[7:2]], a, f3)));
      n_vec++;
      if (obs_lat !== 2) begin
        n_err++;
        $display("FAIL rand_load_lat: got %0d expected 2", obs_lat);
      end
    end
  endtask

  task automatic test_sub_store();
    do_req(1'b1, 3'd0, 32'h15, 32'h0000_00CC, ok_rsp(32'h0));
    ref_mem[5] = ref_store(ref_mem[5], 32'h15, 3'd0, 32'h0000_00CC);
    n_vec++;
    if (obs_lat !== 3 || obs_rd_cyc !== 1 || obs_wr_cyc !== 2 || obs_wr_data !== 32'h8899_CCBB) begin
      n_err++;
      $display("FAIL sb_timing: got lat=%0d rd=%0d wr=%0d data=%h expected 3 1 2 8899ccbb",
               obs_lat, obs_rd_cyc, obs_wr_cyc, obs_wr_data);
    end
    do_req(1'b0, 3'd2, 32'h14, 32'h0, ok_rsp(32'h8899_CCBB));
    do_req(1'b1, 3'd2, 32'h18, 32'hCAFE_F00D, ok_rsp(32'h0));
    ref_mem[6] = 32'hCAFE_F00D;
    n_vec++;
    if (obs_lat !== 2 || obs_rd_cyc !== -1 || obs_wr_cyc !== 1 || obs_wr_data !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL sw_timing: got lat=%0d rd=%0d wr=%0d data=%h expected 2 -1 1 cafef00d",
               obs_lat, obs_rd_cyc, obs_wr_cyc, obs_wr_data);
    end
    // Random sub-word and word stores each followed by a word readback.
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      f3 = 3'($urandom_range(0, 2));
      a  = {$urandom_range(9, 63), 2'b00};
      if (f3 == 3'd0)      a[1:0] = 2'($urandom_range(0, 3));
      else if (f3 == 3'd1) a[1]   = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_req(1'b1, f3, a, wd, ok_rsp(32'h0));
      ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], a, f3, wd);
      do_req(1'b0, 3'd2, {a[31:2], 2'b00}, 32'h0, ok_rsp(ref_mem[a[7:2]]));
    end
  endtask

  task automatic test_errors();
    do_req(1'b1, 3'd2, 32'h16, 32'h1111_2222, err_rsp(ERR_MISALIGN));
    n_vec++;
    if (obs_lat !== 1 || obs_wr_cyc !== -1 || obs_rd_cyc !== -1) begin
      n_err++;
      $display("FAIL sw_misalign_timing: got lat=%0d wr=%0d rd=%0d expected 1 -1 -1",
               obs_lat, obs_wr_cyc, obs_rd_cyc);
    end
    n_vec++;
    if (Mem_Addr !== 32'h0 || wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL idle_bus: got addr=%h wdata=%h expected 0 0", Mem_Addr, wr_data);
    end
    do_req(1'b0, 3'd2, 32'h100, 32'h0, err_rsp(ERR_RANGE));
    do_req(1'b0, 3'd3, 32'h14, 32'h0, err_rsp(ERR_FUNCT3));
    do_req(1'b1, 3'd4, 32'h14, 32'h0, err_rsp(ERR_FUNCT3));
    do_req(1'b0, 3'd3, 32'h101, 32'h0, err_rsp(ERR_FUNCT3));
    do_req(1'b0, 3'd1, 32'h101, 32'h0, err_rsp(ERR_MISALIGN));
    do_req(1'b0, 3'd2, 32'h8000_0014, 32'h0, err_rsp(ERR_RANGE));
    do_req(1'b1, 3'd0, 32'h0000_0115, 32'hFF, err_rsp(ERR_RANGE));
    n_vec++;
    if (obs_wr_cyc !== -1 || mem[5] !== ref_mem[5]) begin
      n_err++;
      $display("FAIL sb_range_nowrite: got wr_cyc=%0d mem5=%h expected -1 %h",
               obs_wr_cyc, mem[5], ref_mem[5]);
    end
    do_req(1'b1, 3'd2, 32'hFC, 32'h5A5A_A5A5, ok_rsp(32'h0));
    ref_mem[63] = 32'h5A5A_A5A5;
    do_req(1'b0, 3'd2, 32'hFC, 32'h0, ok_rsp(32'h5A5A_A5A5));
  endtask

  task automatic test_back_to_back();
    int          n_resp;
    int          first_cyc;
    int          gap;
    logic [34:0] e;
    logic [34:0] got;
    exp_q.push_back(ok_rsp(ref_mem[5]));
    exp_q.push_back(ok_rsp(ref_load(ref_mem[5], 32'h15, 3'd4)));
    n_resp = 0; first_cyc = -1; gap = -1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h14; req_wdata = '0;
    for (int k = 0; k < 20 && n_resp < 2; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_resp++;
        got = {resp_err, resp_err_code, resp_rdata};
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e || req_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_resp%0d: got %h rdy=%b expected %h rdy=0", n_resp, got, req_ready, e);
        end
        if (n_resp == 1) begin
          first_cyc = k;
          req_funct3 = 3'd4; req_addr = 32'h15;
        end else begin
          gap = k - first_cyc;
          req_valid = 1'b0;
        end
      end
    end
    n_vec++;
    if (gap !== 3) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles (resps=%0d) expected 3", gap, n_resp);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic saw_wr;
    logic saw_resp;
    saw_wr = 1'b0; saw_resp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h20; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (MemRead !== 1'b1 || dbg_state !== S_RMW_RD) begin
      n_err++;
      $display("FAIL rmw_entry: got rd=%b state=%0d expected 1 RMW_RD", MemRead, dbg_state);
    end
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (MemWrite !== 1'b0 || MemRead !== 1'b0 || req_ready !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL async_reset: got wr=%b rd=%b rdy=%b state=%0d expected 0 0 0 IDLE",
               MemWrite, MemRead, req_ready, dbg_state);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (MemWrite) saw_wr = 1'b1;
      if (resp_valid) saw_resp = 1'b1;
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b expected 1", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (MemWrite) saw_wr = 1'b1;
      if (resp_valid) saw_resp = 1'b1;
    end
    n_vec++;
    if (saw_wr !== 1'b0 || saw_resp !== 1'b0 || mem[8] !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL interrupted_sh: got wr=%b resp=%b mem8=%h expected 0 0 12345678",
               saw_wr, saw_resp, mem[8]);
    end
  endtask

`ifdef LSU_PERF_CNT_EN
  task automatic test_perf_cnt();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_vec++;
    if (load_cnt !== 32'd0 || store_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL cnt_reset: got %0d %0d %0d expected 0 0 0", load_cnt, store_cnt, err_cnt);
    end
    do_req(1'b0, 3'd2, 32'h14, 32'h0, ok_rsp(ref_mem[5]));
    do_req(1'b0, 3'd0, 32'h17, 32'h0, ok_rsp(ref_load(ref_mem[5], 32'h17, 3'd0)));
    do_req(1'b1, 3'd2, 32'h1C, 32'h0BAD_CAFE, ok_rsp(32'h0));
    ref_mem[7] = 32'h0BAD_CAFE;
    do_req(1'b0, 3'd2, 32'h13, 32'h0, err_rsp(ERR_MISALIGN));
    @(negedge clk);
    n_vec++;
    if (load_cnt !== 32'd2 || store_cnt !== 32'd1 || err_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL perf_cnt: got load=%0d store=%0d err=%0d expected 2 1 1",
               load_cnt, store_cnt, err_cnt);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_loads();
    test_random_loads();
    test_sub_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_PERF_CNT_EN
    test_perf_cnt();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
